maze_neighbor_gen: RTL and testbench
====================================

MAZE_NEIGHBOR_GEN -- requirements
Module: maze_neighbor_gen

Interface
REQ-001 SHALL have parameters: COLS, default 160, maze cells per row; ROWS, default 120, maze cell rows; CELL_LOG2, default 2, log2 of cell size in pixels (4x4 px cells); WORD_W, default 16, maze memory word width.
REQ-002 SHALL have port pixel_clk, input, 1, pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have ports DrawX and DrawY, input, 10 each, current raster pixel; horizontal range 0..799, vertical range 0..524.
REQ-005 SHALL have port mem_rd, output, 1, maze memory read strobe.
REQ-006 SHALL have port mem_addr, output, 11, maze memory word address, equal to row*10+word.
REQ-007 SHALL have port mem_data, input, 16, maze memory read data, valid exactly 1 cycle after mem_rd is asserted; bit j of word i is cell cx=16*i+j; a 1 bit means wall.
REQ-008 SHALL have port currentMazePrime, output, 1, the cell under the pixel is a wall.
REQ-009 SHALL have ports MazeUpPrime, MazeDownPrime, MazeLeftPrime and MazeRightPrime, output, 1 each, the adjacent cell in that direction is a wall.
REQ-010 SHALL have port fetch_busy, output, 1, high while the fetch FSM is not IDLE.

Function
REQ-011 SHALL hold three COLS-bit row registers: rowPrev, rowCur and rowNext, for cell rows cy-1, cy and cy+1, where cy=DrawY>>CELL_LOG2.
REQ-012 SHALL compute cx=DrawX>>CELL_LOG2 and register all five outputs, giving 1-cycle latency: outputs at edge k+1 reflect DrawX/DrawY sampled at edge k.
REQ-013 SHALL set the outputs as follows: currentMazePrime=rowCur[cx]; MazeUpPrime=rowPrev[cx]; MazeDownPrime=rowNext[cx]; MazeLeftPrime=rowCur[cx-1]; MazeRightPrime=rowCur[cx+1].
REQ-014 SHALL force MazeLeftPrime=1 at cx=0 and MazeRightPrime=1 at cx=COLS-1, because the maze border is wall.
REQ-015 SHALL drive all five outputs to 0 when DrawX>=640 or DrawY>=480.
REQ-016 SHALL use fetch FSM states IDLE, PRIME_CUR, PRIME_NEXT, SHIFT, FETCH_NEXT.
REQ-017 SHALL start a prime trigger when DrawY==524 and DrawX==640 in IDLE: rowPrev<=all ones, then go to PRIME_CUR.
REQ-018 SHALL, in PRIME_CUR, read row 0 (addresses 0..9) into rowCur, then go to PRIME_NEXT.
REQ-019 SHALL, in PRIME_NEXT, read row 1 (addresses 10..19) into rowNext, then go to IDLE.
REQ-020 SHALL start a line trigger when DrawX==640, DrawY[1:0]==3 and DrawY<479, in IDLE: go to SHIFT.
REQ-021 SHALL, in SHIFT, load rowPrev<=rowCur and rowCur<=rowNext in one cycle, then go to FETCH_NEXT.
REQ-022 SHALL, in FETCH_NEXT, read row r=(DrawY>>2)+2 into rowNext when r<ROWS; when r>=ROWS it SHALL issue no reads, set rowNext<=all ones, and return to IDLE.
REQ-023 SHALL perform each row read as mem_rd high for exactly 10 consecutive cycles with word addresses ascending; word i SHALL be captured into bits [16i+15:16i] on the cycle after its strobe; a row read takes 11 cycles in total.
REQ-024 SHALL deassert mem_rd and hold mem_addr in all other cycles.
REQ-025 SHALL ignore any trigger that occurs while not in IDLE; no trigger queueing.
REQ-026 SHALL perform row updates only during hblank/vblank, so that rows never change while DrawX<640 on visible lines.

Reset
REQ-027 SHALL, on Reset asserted at any time including mid-fetch, immediately clear FSM to IDLE, all row registers to 0, all outputs to 0, mem_rd to 0, mem_addr to 0 and fetch_busy to 0.
REQ-028 SHALL, after Reset release, present correct maze data only after the next prime trigger; outputs before that SHALL reflect zeroed rows, plus the border forcing of REQ-014.

Verification
REQ-029 SHALL be verified with Reset asserted during active video -> all outputs 0, mem_rd 0, fetch_busy 0 within the same cycle.
REQ-030 SHALL be verified with an all-zero maze and a prime trigger -> mem_rd high for 10 cycles at addresses 0..9, then 10..19 after 1 gap cycle; fetch_busy high for 22 cycles.
REQ-031 SHALL be verified with a maze that has only cell (10,5) as wall, after prime, scanning pixels (40..43,20..23) -> currentMazePrime=1; pixel (44,20) -> MazeLeftPrime=1; pixel (40,24) -> MazeUpPrime=1; pixel (40,19) -> MazeDownPrime=1.
REQ-032 SHALL be verified with an empty maze at pixel (0,0) -> MazeUpPrime=1, MazeLeftPrime=1, currentMazePrime=0; at pixel (639,479) -> MazeRightPrime=1, MazeDownPrime=1.
REQ-033 SHALL be verified with DrawY=3, DrawX=640 -> SHIFT, then reads at addresses 20..29; with DrawY=475, DrawX=640 -> no mem_rd, and MazeDownPrime=1 for visible pixels on rows 476..479.
REQ-034 SHALL be verified with Reset pulsed at the 5th read of FETCH_NEXT -> FSM IDLE, mem_rd 0; the next prime trigger restores correct outputs.

Source files
------------

// File: rtl/maze_neighbor_gen.sv
// Maze neighbour lookup for the raster: keeps three cached maze rows around the current cell row
// and streams the next row from maze memory during horizontal/vertical blanking.
module maze_neighbor_gen #(
    parameter int unsigned COLS      = 160,
    parameter int unsigned ROWS      = 120,
    parameter int unsigned CELL_LOG2 = 2,
    parameter int unsigned WORD_W    = 16
) (
    input  logic              pixel_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              mem_rd,
    output logic [10:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              currentMazePrime,
    output logic              MazeUpPrime,
    output logic              MazeDownPrime,
    output logic              MazeLeftPrime,
    output logic              MazeRightPrime,
    output logic              fetch_busy
);

    localparam int unsigned Words = COLS / WORD_W;
    localparam int unsigned CntW  = $clog2(Words + 1);
    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned AddrW = 11;

    typedef enum logic [2:0] {
        StIdle,
        StPrimeCur,
        StPrimeNext,
        StShift,
        StFetchNext
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [AddrW-1:0]  row_q, row_d;
    logic [COLS-1:0]   row_prev_q, row_prev_d;
    logic [COLS-1:0]   row_cur_q, row_cur_d;
    logic [COLS-1:0]   row_next_q, row_next_d;
    logic              cur_q, cur_d, up_q, up_d, down_q, down_d;
    logic              left_q, left_d, right_q, right_d;

    logic              prime_trig, line_trig, visible;
    logic              in_read, row_ok, reading, capture, last, advance;
    logic [ColW-1:0]   cx, cap_lsb;
    logic [AddrW-1:0]  row_base;

    assign prime_trig = (DrawY == 10'd524) && (DrawX == 10'd640);
    assign line_trig  = (DrawX == 10'd640) && (DrawY[1:0] == 2'b11) && (DrawY < 10'd479);

    assign in_read  = (state_q == StPrimeCur) || (state_q == StPrimeNext) ||
                      (state_q == StFetchNext);
    assign row_ok   = (state_q != StFetchNext) || (row_q < AddrW'(ROWS));
    assign reading  = in_read && row_ok && (cnt_q < CntW'(Words));
    // Memory returns a word one cycle after its strobe, so cnt_q-1 is the word arriving now.
    assign capture  = in_read && (cnt_q != '0);
    assign cap_lsb  = ColW'(32'(cnt_q - CntW'(1)) * WORD_W);
    assign last     = (cnt_q == CntW'(Words));
    assign row_base = row_q * AddrW'(Words);

    assign mem_rd     = reading;
    assign mem_addr   = addr_q;
    assign fetch_busy = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        row_d      = row_q;
        row_prev_d = row_prev_q;
        row_cur_d  = row_cur_q;
        row_next_d = row_next_q;
        advance    = 1'b0;

        if (capture) begin
            if (state_q == StPrimeCur) begin
                row_cur_d[cap_lsb +: WORD_W] = mem_data;
            end else begin
                row_next_d[cap_lsb +: WORD_W] = mem_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (prime_trig) begin
                    row_prev_d = '1;
                    state_d    = StPrimeCur;
                    cnt_d      = '0;
                    addr_d     = '0;
                end else if (line_trig) begin
                    row_d   = AddrW'(DrawY >> CELL_LOG2) + AddrW'(2);
                    state_d = StShift;
                end
            end
            StPrimeCur: begin
                if (last) begin
                    state_d = StPrimeNext;
                    cnt_d   = '0;
                    addr_d  = AddrW'(Words);
                end else begin
                    advance = 1'b1;
                end
            end
            StPrimeNext: begin
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            StShift: begin
                row_prev_d = row_cur_q;
                row_cur_d  = row_next_q;
                state_d    = StFetchNext;
                cnt_d      = '0;
                if (row_q < AddrW'(ROWS)) begin
                    addr_d = row_base;
                end
            end
            StFetchNext: begin
                // Below the last maze row everything is border wall.
                if (!row_ok) begin
                    row_next_d = '1;
                    state_d    = StIdle;
                end else if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q < CntW'(Words - 1)) begin
                addr_d = addr_q + AddrW'(1);
            end
        end
    end

    assign cx      = ColW'(DrawX >> CELL_LOG2);
    assign visible = (DrawX < 10'd640) && (DrawY < 10'd480);

    always_comb begin
        cur_d   = visible & row_cur_q[cx];
        up_d    = visible & row_prev_q[cx];
        down_d  = visible & row_next_q[cx];
        left_d  = visible & ((cx == '0) | row_cur_q[cx - ColW'(1)]);
        right_d = visible & ((cx == ColW'(COLS - 1)) | row_cur_q[cx + ColW'(1)]);
    end

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            row_prev_q <= '0;
            row_cur_q  <= '0;
            row_next_q <= '0;
            cur_q      <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            row_prev_q <= row_prev_d;
            row_cur_q  <= row_cur_d;
            row_next_q <= row_next_d;
            cur_q      <= cur_d;
            up_q       <= up_d;
            down_q     <= down_d;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    assign currentMazePrime = cur_q;
    assign MazeUpPrime      = up_q;
    assign MazeDownPrime    = down_q;
    assign MazeLeftPrime    = left_q;
    assign MazeRightPrime   = right_q;

endmodule

// File: tb/tb_maze_neighbor_gen.sv
// Directed bench for maze_neighbor_gen: a behavioural maze memory, a vector table of pixel
// lookups with hand-computed neighbour flags, and fetch/reset sequences checked cycle by cycle.
module tb_maze_neighbor_gen;

    logic        pixel_clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        mem_rd;
    logic [10:0] mem_addr;
    logic [15:0] mem_data = 16'h0;
    logic        currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime, MazeRightPrime;
    logic        fetch_busy;
    logic [4:0]  nbr;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_line = -1;

    logic [159:0] maze [0:127];

    typedef struct {
        string      name;
        int         ln;
        int         x;
        int         y;
        logic [4:0] want;
    } vec_t;
    vec_t tbl[$];

    maze_neighbor_gen dut (
        .pixel_clk        (pixel_clk),
        .Reset            (Reset),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .currentMazePrime (currentMazePrime),
        .MazeUpPrime      (MazeUpPrime),
        .MazeDownPrime    (MazeDownPrime),
        .MazeLeftPrime    (MazeLeftPrime),
        .MazeRightPrime   (MazeRightPrime),
        .fetch_busy       (fetch_busy)
    );

    always #5 pixel_clk = ~pixel_clk;

    // {cur, up, down, left, right}
    assign nbr = {currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime, MazeRightPrime};

    always @(posedge pixel_clk) begin
        if (mem_rd) mem_data <= maze[mem_addr / 10][(mem_addr % 10) * 16 +: 16];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic clear_maze();
        for (int r = 0; r < 128; r++) maze[r] = '0;
    endtask

    task automatic pixel(input string name, input int x, input int y, input logic [4:0] want);
        @(negedge pixel_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge pixel_clk);
        check(name, 32'(nbr), 32'(want));
    endtask

    // Prime trigger, then two 10-word reads separated by one gap cycle.
    task automatic prime_check(input string tag);
        int busy = 0, bad = 0;
        logic exp_rd;
        int exp_addr;
        @(negedge pixel_clk);
        DrawX = 10'd640;
        DrawY = 10'd524;
        for (int c = 0; c < 30; c++) begin
            @(negedge pixel_clk);
            if (c == 0) DrawX = 10'd700;
            if (fetch_busy) busy++;
            exp_rd   = (c < 10) || (c >= 11 && c < 21);
            exp_addr = (c <= 10) ? ((c < 10) ? c : 9) : c - 1;
            if (mem_rd !== exp_rd) bad++;
            if ((exp_rd || c == 10) && mem_addr !== 11'(exp_addr)) bad++;
        end
        check({tag, "_busy_cycles"}, 32'(busy), 32'd22);
        check({tag, "_read_seq_errors"}, 32'(bad), 32'd0);
    endtask

    // Line trigger at row y: SHIFT, then either 10 reads of row y/4+2 or the border fill.
    task automatic do_line(input int y);
        int r, busy = 0, bad = 0;
        logic exp_rd;
        r = y / 4 + 2;
        @(negedge pixel_clk);
        DrawX = 10'd640;
        DrawY = 10'(y);
        for (int c = 0; c < 16; c++) begin
            @(negedge pixel_clk);
            if (c == 0) DrawX = 10'd700;
            if (fetch_busy) busy++;
            exp_rd = (r < 120) && (c >= 1) && (c <= 10);
            if (mem_rd !== exp_rd) bad++;
            if (exp_rd && mem_addr !== 11'(r * 10 + c - 1)) bad++;
        end
        check($sformatf("line%0d_busy_cycles", y), 32'(busy), (r < 120) ? 32'd12 : 32'd2);
        check($sformatf("line%0d_read_seq_errors", y), 32'(bad), 32'd0);
    endtask

    initial begin
        int busy, rds, n;

        Reset = 1'b1;
        DrawX = 10'd700;
        DrawY = 10'd500;
        clear_maze();
        repeat (3) @(negedge pixel_clk);
        check("reset_outputs", 32'(nbr), 32'd0);
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_busy", 32'(fetch_busy), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        Reset = 1'b0;

        // Zeroed rows before any prime: only the left/right border forcing shows.
        pixel("preprime_0_0", 0, 0, 5'b00010);
        pixel("preprime_639_10", 639, 10, 5'b00001);
        pixel("preprime_40_40", 40, 40, 5'b00000);

        maze[5][10] = 1'b1;
        prime_check("prime1");

        tbl.push_back('{"p_0_0",      -1,   0,   0, 5'b01010});
        tbl.push_back('{"p_40_0",     -1,  40,   0, 5'b01000});
        tbl.push_back('{"p_639_0",    -1, 639,   0, 5'b01001});
        tbl.push_back('{"p_640_0",    -1, 640,   0, 5'b00000});
        tbl.push_back('{"p_100_480",  -1, 100, 480, 5'b00000});
        tbl.push_back('{"p_40_19",    15,  40,  19, 5'b00100});
        tbl.push_back('{"p_40_16",    15,  40,  16, 5'b00100});
        tbl.push_back('{"p_44_19",    15,  44,  19, 5'b00000});
        tbl.push_back('{"p_36_19",    15,  36,  19, 5'b00000});
        tbl.push_back('{"p_40_20",    19,  40,  20, 5'b10000});
        tbl.push_back('{"p_43_23",    19,  43,  23, 5'b10000});
        tbl.push_back('{"p_44_20",    19,  44,  20, 5'b00010});
        tbl.push_back('{"p_36_20",    19,  36,  20, 5'b00001});
        tbl.push_back('{"p_48_20",    19,  48,  20, 5'b00000});
        tbl.push_back('{"p_40_24",    23,  40,  24, 5'b01000});
        tbl.push_back('{"p_42_27",    23,  42,  27, 5'b01000});
        tbl.push_back('{"p_44_24",    23,  44,  24, 5'b00000});
        tbl.push_back('{"p_639_479", 475, 639, 479, 5'b00101});
        tbl.push_back('{"p_0_476",   475,   0, 476, 5'b00110});
        tbl.push_back('{"p_320_478", 475, 320, 478, 5'b00100});
        tbl.push_back('{"p_639_480", 475, 639, 480, 5'b00000});
        tbl.push_back('{"p_640_479", 475, 640, 479, 5'b00000});

        foreach (tbl[i]) begin
            while (cur_line < tbl[i].ln) begin
                cur_line = (cur_line < 0) ? 3 : cur_line + 4;
                do_line(cur_line);
            end
            pixel(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].want);
        end

        // Row 479 is past the last line trigger.
        @(negedge pixel_clk);
        DrawX = 10'd640;
        DrawY = 10'd479;
        busy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge pixel_clk);
            if (fetch_busy || mem_rd) busy++;
        end
        check("line479_no_trigger", 32'(busy), 32'd0);

        // Reset during active video clears everything within the cycle.
        pixel("pre_reset_100_100", 100, 100, 5'b00100);
        #2 Reset = 1'b1;
        #1;
        check("active_reset_outputs", 32'(nbr), 32'd0);
        check("active_reset_mem_rd", 32'(mem_rd), 32'd0);
        check("active_reset_busy", 32'(fetch_busy), 32'd0);
        check("active_reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge pixel_clk);
        Reset = 1'b0;
        pixel("post_reset_0_0", 0, 0, 5'b00010);

        clear_maze();
        maze[0][17]  = 1'b1;
        maze[1][159] = 1'b1;
        prime_check("prime2");

        // Reset on the 5th read of a row fetch.
        @(negedge pixel_clk);
        DrawX = 10'd640;
        DrawY = 10'd3;
        rds = 0;
        n   = 0;
        while (rds < 5 && n < 30) begin
            @(negedge pixel_clk);
            DrawX = 10'd700;
            n++;
            if (mem_rd) rds++;
        end
        check("fetch_5th_read_reached", 32'(rds), 32'd5);
        #1 Reset = 1'b1;
        #1;
        check("midfetch_reset_busy", 32'(fetch_busy), 32'd0);
        check("midfetch_reset_mem_rd", 32'(mem_rd), 32'd0);
        check("midfetch_reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge pixel_clk);
        Reset = 1'b0;
        busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pixel_clk);
            if (fetch_busy || mem_rd) busy++;
        end
        check("midfetch_reset_stays_idle", 32'(busy), 32'd0);
        pixel("midfetch_zero_rows_68_0", 68, 0, 5'b00000);

        prime_check("prime3");
        pixel("m2_68_0", 68, 0, 5'b11000);
        pixel("m2_72_0", 72, 0, 5'b01010);
        pixel("m2_636_0", 636, 0, 5'b01101);
        do_line(3);
        pixel("m2_68_4", 68, 4, 5'b01000);
        pixel("m2_636_4", 636, 4, 5'b10001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
